// File: rtl/axi4s_add_bytes_sched.sv
// Packet-level round-robin scheduler sharing one pad datapath between NUM_PORTS AXI4-Stream sources.
// Optional build macro AXI4S_ADD_BYTES_SCHED_PRIO_EN makes port 0 strict priority over the round-robin ports.
module axi4s_add_bytes_sched #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 4,
    parameter int BURST      = 1,
    localparam int ID_W      = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_tdata,
    input  logic [NUM_PORTS*USER_WIDTH-1:0]  s_tuser,
    input  logic [NUM_PORTS-1:0]             s_tlast,
    input  logic [NUM_PORTS-1:0]             s_tvalid,
    output logic [NUM_PORTS-1:0]             s_tready,
    output logic [DATA_WIDTH-1:0]            m_tdata,
    output logic [USER_WIDTH-1:0]            m_tuser,
    output logic                             m_tlast,
    output logic                             m_tvalid,
    input  logic                             m_tready,
    output logic [ID_W-1:0]                  m_tid,
    output logic                             busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PASS = 1'b1;

    localparam int            IDX_W = ID_W + 1;
    localparam logic [ID_W:0] NP    = IDX_W'(NUM_PORTS);

    logic [0:0]      state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] burst_port;
    logic [7:0]      burst_cnt;

    logic [ID_W:0]   idx;
    logic [ID_W-1:0] rr_pick;
    logic            rr_found;
    logic            any_req;
    logic            keep_burst;
    logic            prio_hit;
    logic            prio_grant;
    logic [ID_W-1:0] next_grant;
    logic [ID_W:0]   grant_inc;
    logic [ID_W-1:0] rr_next;
    logic            sel_tvalid;
    logic            pkt_end;
    logic            burst_more;

`ifdef AXI4S_ADD_BYTES_SCHED_PRIO_EN
    assign prio_hit   = s_tvalid[0];
    assign prio_grant = (grant == '0);
`else
    assign prio_hit   = 1'b0;
    assign prio_grant = 1'b0;
`endif

    assign any_req    = |s_tvalid;
    assign keep_burst = (burst_cnt != 8'd0) && s_tvalid[burst_port];

    // Rotating search starting at rr_ptr; idx wraps mod NUM_PORTS so unused indices are never visited.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        idx      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = {1'b0, rr_ptr} + IDX_W'(i);
            if (idx >= NP) begin
                idx = idx - NP;
            end
`ifdef AXI4S_ADD_BYTES_SCHED_PRIO_EN
            if (!rr_found && (idx != '0) && s_tvalid[idx[ID_W-1:0]]) begin
`else
            if (!rr_found && s_tvalid[idx[ID_W-1:0]]) begin
`endif
                rr_found = 1'b1;
                rr_pick  = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        if (prio_hit) begin
            next_grant = '0;
        end else if (keep_burst) begin
            next_grant = burst_port;
        end else begin
            next_grant = rr_pick;
        end
    end

    assign grant_inc  = {1'b0, grant} + IDX_W'(1);
    assign rr_next    = (grant_inc == NP) ? '0 : grant_inc[ID_W-1:0];
    assign burst_more = ({1'b0, burst_cnt} + 9'd1) < 9'(BURST);

    assign busy  = (state == ST_PASS);
    assign m_tid = grant;

    // Zero-latency pass-through of the granted port; valid never looks at m_tready.
    always_comb begin
        m_tdata    = '0;
        m_tuser    = '0;
        m_tlast    = 1'b0;
        sel_tvalid = 1'b0;
        s_tready   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant == ID_W'(p)) begin
                m_tdata    = s_tdata[p*DATA_WIDTH +: DATA_WIDTH];
                m_tuser    = s_tuser[p*USER_WIDTH +: USER_WIDTH];
                m_tlast    = s_tlast[p];
                sel_tvalid = s_tvalid[p];
                s_tready[p] = busy & m_tready;
            end
        end
    end

    assign m_tvalid = busy & sel_tvalid;
    assign pkt_end  = m_tvalid & m_tready & m_tlast;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            grant      <= '0;
            burst_port <= '0;
            burst_cnt  <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Losing burst continuation drops the count even when nobody requests.
                    if (!prio_hit && !keep_burst) begin
                        burst_cnt <= 8'd0;
                        if (any_req) begin
                            burst_port <= rr_pick;
                        end
                    end
                    if (any_req) begin
                        grant <= next_grant;
                        state <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (pkt_end) begin
                        state <= ST_IDLE;
                        if (!prio_grant) begin
                            if (burst_more) begin
                                burst_cnt <= burst_cnt + 8'd1;
                            end else begin
                                burst_cnt <= 8'd0;
                                rr_ptr    <= rr_next;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4s_add_bytes_sched.sv
// Randomized bench for axi4s_add_bytes_sched against a packet-level scheduling model.
// Honors AXI4S_ADD_BYTES_SCHED_PRIO_EN when the build defines it.
module tb_axi4s_add_bytes_sched;

    localparam int NP    = 3;
    localparam int DW    = 16;
    localparam int UW    = 4;
    localparam int BURST = 2;
    localparam int IDW   = 2;
    localparam int NCYC  = 3000;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NP*DW-1:0]   s_tdata;
    logic [NP*UW-1:0]   s_tuser;
    logic [NP-1:0]      s_tlast;
    logic [NP-1:0]      s_tvalid;
    logic [NP-1:0]      s_tready;
    logic [DW-1:0]      m_tdata;
    logic [UW-1:0]      m_tuser;
    logic               m_tlast;
    logic               m_tvalid;
    logic               m_tready;
    logic [IDW-1:0]     m_tid;
    logic               busy;

    always #5 clk = ~clk;

    axi4s_add_bytes_sched #(
        .NUM_PORTS (NP),
        .DATA_WIDTH(DW),
        .USER_WIDTH(UW),
        .BURST     (BURST)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_tdata (s_tdata),
        .s_tuser (s_tuser),
        .s_tlast (s_tlast),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .m_tdata (m_tdata),
        .m_tuser (m_tuser),
        .m_tlast (m_tlast),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tid   (m_tid),
        .busy    (busy)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    beat_t srcq[NP][$];

    int n_chk  = 0;
    int n_fail = 0;

    // Model: serving flag, granted port, rr pointer, burst count, last round-robin winner.
    int m_serv, m_g, m_rr, m_bcnt, m_last, m_beats, n_resets;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_pkt(input int p);
        int    len;
        beat_t b;
        len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++) begin
            b.d = DW'($urandom);
            b.u = UW'($urandom);
            b.l = (k == len - 1);
            srcq[p].push_back(b);
        end
    endtask

    task automatic model_reset();
        m_serv  = 0;
        m_rr    = 0;
        m_bcnt  = 0;
        m_last  = 0;
        m_g     = 0;
        m_beats = 0;
        for (int p = 0; p < NP; p++) srcq[p].delete();
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            if (srcq[p].size() == 0 && $urandom_range(1) == 0) push_pkt(p);
            if (srcq[p].size() > 0 && $urandom_range(3) != 0) begin
                s_tvalid[p]          = 1'b1;
                s_tdata[p*DW +: DW]  = srcq[p][0].d;
                s_tuser[p*UW +: UW]  = srcq[p][0].u;
                s_tlast[p]           = srcq[p][0].l;
            end else begin
                s_tvalid[p]          = 1'b0;
                s_tdata[p*DW +: DW]  = DW'($urandom);
                s_tuser[p*UW +: UW]  = UW'($urandom);
                s_tlast[p]           = 1'($urandom);
            end
        end
        m_tready = ($urandom_range(3) != 0);
    endtask

    task automatic check_and_step();
        logic [NP-1:0] v;
        logic [NP-1:0] exp_rdy;
        beat_t         b;
        int            p;
        bit            cont, prio, prio_grant;
        v = s_tvalid;
        if (m_serv == 0) begin
            check("idle_busy", busy, 0);
            check("idle_mvalid", m_tvalid, 0);
            check("idle_sready", s_tready, 0);
            p    = -1;
            prio = 1'b0;
            cont = 1'b0;
`ifdef AXI4S_ADD_BYTES_SCHED_PRIO_EN
            if (v[0]) begin
                p    = 0;
                prio = 1'b1;
            end
`endif
            if (p < 0 && m_bcnt != 0 && v[m_last]) begin
                p    = m_last;
                cont = 1'b1;
            end
            if (p < 0) begin
                for (int k = 0; k < NP; k++) begin
                    int q;
                    q = (m_rr + k) % NP;
`ifdef AXI4S_ADD_BYTES_SCHED_PRIO_EN
                    if (q == 0) continue;
`endif
                    if (v[q]) begin
                        p = q;
                        break;
                    end
                end
            end
            if (!prio && !cont) begin
                m_bcnt = 0;
                if (p >= 0) m_last = p;
            end
            if (p >= 0) begin
                m_g     = p;
                m_serv  = 1;
                m_beats = 0;
            end
        end else begin
            exp_rdy = m_tready ? NP'(1 << m_g) : '0;
            check("pass_busy", busy, 1);
            check("pass_tid", m_tid, m_g);
            check("pass_mvalid", m_tvalid, v[m_g]);
            check("pass_sready", s_tready, exp_rdy);
            if (v[m_g]) begin
                b = srcq[m_g][0];
                check("pass_tdata", m_tdata, b.d);
                check("pass_tuser", m_tuser, b.u);
                check("pass_tlast", m_tlast, b.l);
                if (m_tready) begin
                    void'(srcq[m_g].pop_front());
                    m_beats++;
                    if (b.l) begin
                        prio_grant = 1'b0;
`ifdef AXI4S_ADD_BYTES_SCHED_PRIO_EN
                        prio_grant = (m_g == 0);
`endif
                        if (!prio_grant) begin
                            if (m_bcnt + 1 < BURST) begin
                                m_bcnt++;
                            end else begin
                                m_bcnt = 0;
                                m_rr   = (m_g + 1) % NP;
                            end
                        end
                        m_serv = 0;
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_mvalid", m_tvalid, 0);
        check("rst_sready", s_tready, 0);
        check("rst_busy", busy, 0);
        check("rst_tid", m_tid, 0);
        s_tvalid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        n_resets++;
    endtask

    initial begin
        rst_n    = 1'b0;
        s_tdata  = '0;
        s_tuser  = '0;
        s_tlast  = '0;
        s_tvalid = '0;
        m_tready = 1'b0;
        n_resets = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init_busy", busy, 0);
        check("init_mvalid", m_tvalid, 0);
        check("init_sready", s_tready, 0);
        check("init_tid", m_tid, 0);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            drive();
            if (n_resets < 2 && cyc > 800 * (n_resets + 1) && m_serv != 0 && m_beats == 1) begin
                do_reset();
                continue;
            end
            @(negedge clk);
            check_and_step();
        end
        check("reset_pulses", n_resets, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
